// File: rtl/fifo_syn_counter_methods_pkg.sv
// Shared constants and helpers for the counter-based synchronous FIFO.
package fifo_pkg;

  localparam int FIFO_DEPTH_DEF = 8;
  localparam int FIFO_WIDTH_DEF = 16;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_syn_counter_methods_if.sv
// Producer/consumer bus of the FIFO; master drives requests, slave is the FIFO.
interface fifo_syn_counter_methods_if
  import fifo_pkg::*;
#(
  parameter int Width = FIFO_WIDTH_DEF
);
  logic             w_en;
  logic             r_en;
  logic [Width-1:0] in_data;
  logic [Width-1:0] out_data;
  logic             full;
  logic             empty;

  modport master (output w_en, r_en, in_data, input out_data, full, empty);
  modport slave  (input w_en, r_en, in_data, output out_data, full, empty);
endinterface

// File: rtl/fifo_syn_mem.sv
// 1-write/1-read register file with a registered read port; storage is not reset.
module fifo_syn_mem
  import fifo_pkg::*;
#(
  parameter int Depth = FIFO_DEPTH_DEF,
  parameter int Width = FIFO_WIDTH_DEF,
  parameter int AddrW = ptr_w(FIFO_DEPTH_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic             re,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [Width-1:0] rdata_q;
  logic [Width-1:0] rdata_d;

  // Read uses mem_q, so a same-edge write to the read slot returns the old word.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_syn_counter_methods.sv
// Single-clock FIFO whose full/empty flags decode from an explicit occupancy counter.
module fifo_syn_counter_methods
  import fifo_pkg::*;
#(
  parameter int Depth = FIFO_DEPTH_DEF,
  parameter int Width = FIFO_WIDTH_DEF
) (
  input logic                            clk,
  input logic                            rst,
  fifo_syn_counter_methods_if.slave      bus
);

  localparam int PtrW = ptr_w(Depth);
  localparam int CntW = PtrW + 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            wr_ok;
  logic            rd_ok;
  logic            full;
  logic            empty;

  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);

  // A write into a full FIFO is still accepted when a read frees a slot that edge.
  assign wr_ok = bus.w_en && (!full || bus.r_en);
  assign rd_ok = bus.r_en && !empty;

  // Explicit wrap so non-power-of-2 depths work.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_syn_mem #(
    .Depth (Depth),
    .Width (Width),
    .AddrW (PtrW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wr_ptr_q),
    .wdata (bus.in_data),
    .re    (rd_ok),
    .raddr (rd_ptr_q),
    .rdata (bus.out_data)
  );

  assign bus.full  = full;
  assign bus.empty = empty;

endmodule

// File: tb/tb_fifo_syn_counter_methods.sv
// Directed bench for fifo_syn_counter_methods (Depth 8, Width 16).
module tb_fifo_syn_counter_methods;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  fifo_syn_counter_methods_if #(.Width(16)) bus ();

  fifo_syn_counter_methods #(
    .Depth (8),
    .Width (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the edge so they are stable at the next edge and sampled there.
  task automatic step(input logic w, input logic r, input logic [15:0] d);
    bus.w_en    = w;
    bus.r_en    = r;
    bus.in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic exp_full, input logic exp_empty);
    chk({tag, "_full"},  {31'b0, bus.full},  {31'b0, exp_full});
    chk({tag, "_empty"}, {31'b0, bus.empty}, {31'b0, exp_empty});
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b0;
    bus.w_en    = 1'b0;
    bus.r_en    = 1'b0;
    bus.in_data = '0;

    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    chk_flags("reset", 1'b0, 1'b1);
    chk("reset_out", {16'b0, bus.out_data}, 32'h0);
    rst = 1'b1;

    for (int i = 1; i <= 11; i++) begin
      step(1'b1, 1'b0, 16'(i));
      chk_flags($sformatf("overfill%0d", i), (i >= 8), 1'b0);
    end

    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1, 16'h0);
      chk($sformatf("drain_out%0d", k), {16'b0, bus.out_data}, (k <= 8) ? k : 8);
      chk_flags($sformatf("drain%0d", k), 1'b0, (k >= 8));
    end

    for (int i = 101; i <= 108; i++) begin
      step(1'b1, 1'b0, 16'(i));
    end
    chk_flags("refill", 1'b1, 1'b0);

    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b1, 16'(108 + k));
      chk($sformatf("rw_full_out%0d", k), {16'b0, bus.out_data}, 100 + k);
      chk_flags($sformatf("rw_full%0d", k), 1'b1, 1'b0);
    end

    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b1, 16'h0);
      chk($sformatf("drain2_out%0d", k), {16'b0, bus.out_data}, 120 + k);
    end
    chk_flags("drain2", 1'b0, 1'b1);

    step(1'b1, 1'b1, 16'hAAAA);
    chk("rw_empty_out", {16'b0, bus.out_data}, 32'd128);
    chk_flags("rw_empty", 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h0);
    chk("rw_empty_read", {16'b0, bus.out_data}, 32'hAAAA);
    chk_flags("rw_empty_read", 1'b0, 1'b1);

    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b0, 16'(16'h0050 + i));
    end
    chk_flags("midfill", 1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0, 16'h0);
    rst = 1'b1;
    chk_flags("mid_reset", 1'b0, 1'b1);
    chk("mid_reset_out", {16'b0, bus.out_data}, 32'h0);

    step(1'b1, 1'b0, 16'h1234);
    chk_flags("post_reset_wr", 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h0);
    chk("post_reset_rd", {16'b0, bus.out_data}, 32'h1234);
    chk_flags("post_reset_rd", 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h0);
    chk("read_empty_hold", {16'b0, bus.out_data}, 32'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
